mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory (1-cycle read
// latency) between an instruction-fetch port and a data port. The data port
// may issue scalar accesses or VECT_LEN-word vector bursts.
//
// Arbitration policy is selected at build time by the macro ARB_ROUND_ROBIN_EN:
//   undefined : fixed priority, data port over fetch port
//   defined   : on a tie the port not granted most recently wins (fetch first)
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-low reset
//   if_req_i/if_addr_i      fetch request and address
//   if_gnt_o                fetch grant (combinational, issue cycle)
//   if_rvalid_o/if_rdata_o  fetch read data, one cycle after grant
//   dm_req_i/dm_we_i/dm_vec_i/dm_addr_i/dm_wdata_i
//                           data request; lane k of dm_wdata_i is beat k
//   dm_gnt_o                data grant (scalar: issue cycle, vector: last beat)
//   dm_rvalid_o/dm_rdata_o  data read response; lane 0 in the low bits
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i
//                           memory side
//   stall_o                 a requester is waiting this cycle
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned VECT_LEN = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         if_req_i,
    input  logic [ADDR_W-1:0]            if_addr_i,
    output logic                         if_gnt_o,
    output logic                         if_rvalid_o,
    output logic [DATA_W-1:0]            if_rdata_o,
    input  logic                         dm_req_i,
    input  logic                         dm_we_i,
    input  logic                         dm_vec_i,
    input  logic [ADDR_W-1:0]            dm_addr_i,
    input  logic [DATA_W*VECT_LEN-1:0]   dm_wdata_i,
    output logic                         dm_gnt_o,
    output logic                         dm_rvalid_o,
    output logic [DATA_W*VECT_LEN-1:0]   dm_rdata_o,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    input  logic [DATA_W-1:0]            mem_rdata_i,
    output logic                         stall_o
);

    localparam int unsigned CNT_W = (VECT_LEN > 1) ? $clog2(VECT_LEN) : 1;
    localparam int unsigned VEC_W = DATA_W * VECT_LEN;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VECT_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        VEC  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_beat_c;

    // Burst parameters captured on VEC entry
    logic               vec_load_c;
    logic [ADDR_W-1:0]  vec_addr_q;
    logic               vec_we_q;
    logic [VEC_W-1:0]   vec_wdata_q;

    // Read-response tracking, one cycle behind issue
    logic               if_rv_q, if_rv_d;
    logic               dm_sc_rv_q, dm_sc_rv_d;
    logic               vec_done_q, vec_done_d;
    logic               beat_rd_q, beat_rd_d;
    logic [CNT_W-1:0]   beat_lane_q, beat_lane_d;
    logic [DATA_W-1:0]  lane_q [VECT_LEN];
    logic [VEC_W-1:0]   vec_rdata_c;

    logic               dm_win_c, if_win_c;

    // Arbitration among requests present this cycle
`ifdef ARB_ROUND_ROBIN_EN
    logic last_dm_q;    // 1: data port was granted most recently

    assign dm_win_c = (dm_req_i && if_req_i) ? ~last_dm_q : dm_req_i;
    assign if_win_c = if_req_i & ~dm_win_c;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_dm_q <= 1'b1;
        end else if (if_gnt_o) begin
            last_dm_q <= 1'b0;
        end else if (dm_gnt_o) begin
            last_dm_q <= 1'b1;
        end
    end
`else
    assign dm_win_c = dm_req_i;
    assign if_win_c = if_req_i & ~dm_req_i;
`endif

    // Next-state, memory issue and grant decode; everything idles in reset
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_load_c  = 1'b0;
        if_gnt_o    = 1'b0;
        dm_gnt_o    = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_rv_d     = 1'b0;
        dm_sc_rv_d  = 1'b0;
        vec_done_d  = 1'b0;
        beat_rd_d   = 1'b0;
        beat_lane_d = cnt_q;
        last_beat_c = (cnt_q == LAST_BEAT);

        if (rst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (dm_win_c) begin
                        mem_en_o    = 1'b1;
                        mem_we_o    = dm_we_i;
                        mem_addr_o  = dm_addr_i;
                        mem_wdata_o = dm_wdata_i[DATA_W-1:0];
                        if (dm_vec_i) begin
                            // Beat 0 goes out from IDLE; remaining beats from VEC
                            beat_rd_d = ~dm_we_i;
                            if (last_beat_c) begin
                                dm_gnt_o   = 1'b1;
                                vec_done_d = ~dm_we_i;
                            end else begin
                                vec_load_c = 1'b1;
                                state_d    = VEC;
                                cnt_d      = cnt_q + CNT_W'(1);
                            end
                        end else begin
                            dm_gnt_o   = 1'b1;
                            dm_sc_rv_d = ~dm_we_i;
                        end
                    end else if (if_win_c) begin
                        mem_en_o    = 1'b1;
                        mem_addr_o  = if_addr_i;
                        mem_wdata_o = dm_wdata_i[DATA_W-1:0];
                        if_gnt_o    = 1'b1;
                        if_rv_d     = 1'b1;
                    end
                end
                VEC: begin
                    mem_en_o    = 1'b1;
                    mem_we_o    = vec_we_q;
                    mem_addr_o  = vec_addr_q + ADDR_W'(cnt_q);
                    mem_wdata_o = vec_wdata_q[cnt_q*DATA_W +: DATA_W];
                    beat_rd_d   = ~vec_we_q;
                    if (last_beat_c) begin
                        dm_gnt_o   = 1'b1;
                        vec_done_d = ~vec_we_q;
                        state_d    = IDLE;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, beat counter and response flags
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            if_rv_q     <= 1'b0;
            dm_sc_rv_q  <= 1'b0;
            vec_done_q  <= 1'b0;
            beat_rd_q   <= 1'b0;
            beat_lane_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if_rv_q     <= if_rv_d;
            dm_sc_rv_q  <= dm_sc_rv_d;
            vec_done_q  <= vec_done_d;
            beat_rd_q   <= beat_rd_d;
            beat_lane_q <= beat_lane_d;
        end
    end

    // Burst capture so a requester dropping req mid-burst cannot disturb it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vec_addr_q  <= '0;
            vec_we_q    <= 1'b0;
            vec_wdata_q <= '0;
        end else if (vec_load_c) begin
            vec_addr_q  <= dm_addr_i;
            vec_we_q    <= dm_we_i;
            vec_wdata_q <= dm_wdata_i;
        end
    end

    // Lane collector: read data returns the cycle after each beat
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned k = 0; k < VECT_LEN; k++) begin
                lane_q[k] <= '0;
            end
        end else if (beat_rd_q) begin
            lane_q[beat_lane_q] <= mem_rdata_i;
        end
    end

    // The final lane is still on mem_rdata_i when the burst response fires
    always_comb begin
        vec_rdata_c = '0;
        for (int unsigned k = 0; k < VECT_LEN; k++) begin
            if (k == VECT_LEN - 1) begin
                vec_rdata_c[k*DATA_W +: DATA_W] = mem_rdata_i;
            end else begin
                vec_rdata_c[k*DATA_W +: DATA_W] = lane_q[k];
            end
        end
    end

    assign if_rvalid_o = if_rv_q;
    assign if_rdata_o  = if_rv_q ? mem_rdata_i : '0;
    assign dm_rvalid_o = dm_sc_rv_q | vec_done_q;
    assign dm_rdata_o  = vec_done_q ? vec_rdata_c :
                         dm_sc_rv_q ? VEC_W'(mem_rdata_i) : '0;
    assign stall_o     = rst_i & ((if_req_i & ~if_gnt_o) | (dm_req_i & ~dm_gnt_o));

endmodule
